// File: rtl/cmp_arbiter_pkg.sv
// rtl/cmp_arbiter_pkg.sv - shared encodings for the comparator arbiter and condition evaluator
package cmp_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EVAL  = 2'd2
  } state_t;

  localparam logic OP_CMP  = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_NE     = 3'd2;
  localparam logic [2:0] COND_GT     = 3'd3;
  localparam logic [2:0] COND_LT     = 3'd4;
  localparam logic [2:0] COND_GE     = 3'd5;
  localparam logic [2:0] COND_LE     = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_GT = 1;

endpackage

// File: rtl/cmp_arbiter_cond_eval.sv
// rtl/cmp_arbiter_cond_eval.sv - maps a condition code and eq/gt flags to a taken bit
module cond_eval
  import cmp_arbiter_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [1:0] flags,
  output logic       taken
);

  logic eq;
  logic gt;

  assign eq = flags[FLAG_EQ];
  assign gt = flags[FLAG_GT];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_EQ:     taken = eq;
      COND_NE:     taken = ~eq;
      COND_GT:     taken = gt;
      COND_LT:     taken = ~eq & ~gt;
      COND_GE:     taken = eq | gt;
      COND_LE:     taken = ~gt;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin sharing of one comparator between decode and the counter unit
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             op0,
  input  logic [2:0]       cond0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [2:0]       cond1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             taken,
  output logic [WIDTH-1:0] result_flags,
  output logic             busy,
  output logic             cmp_compare,
  output logic             cmp_load,
  output logic [WIDTH-1:0] cmp_bus1,
  output logic [WIDTH-1:0] cmp_bus2,
  input  logic [WIDTH-1:0] cmp_flags
);

  state_t           state;
  state_t           state_nx;
  logic             grant;
  logic             pick;
  logic             last_win;
  logic             lat_op;
  logic [2:0]       lat_cond;
  logic [WIDTH-1:0] bus1_q;
  logic [WIDTH-1:0] bus2_q;
  logic             cond_taken;

  // On a tie the requester that did not win last time goes next.
  assign pick = (req0 && req1) ? ~last_win : req1;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant    = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nx = ST_EVAL;
      ST_EVAL:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  cond_eval u_cond_eval (
    .cond  (lat_cond),
    .flags (cmp_flags[FLAG_GT:FLAG_EQ]),
    .taken (cond_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_win     <= 1'b1;
      lat_op       <= OP_CMP;
      lat_cond     <= COND_ALWAYS;
      bus1_q       <= '0;
      bus2_q       <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      taken        <= 1'b0;
      result_flags <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (grant) begin
        last_win <= pick;
        lat_op   <= pick ? op1 : op0;
        lat_cond <= pick ? cond1 : cond0;
        bus1_q   <= pick ? a1 : a0;
        bus2_q   <= pick ? b1 : b0;
        gnt0     <= ~pick;
        gnt1     <= pick;
      end
      // last_win still names the owner of the operation being evaluated.
      if (state == ST_EVAL) begin
        done0        <= ~last_win;
        done1        <= last_win;
        result_flags <= cmp_flags;
        taken        <= cond_taken;
      end
    end
  end

  assign busy        = (state != ST_IDLE);
  assign cmp_compare = (state == ST_ISSUE) && (lat_op == OP_CMP);
  assign cmp_load    = (state == ST_ISSUE) && (lat_op == OP_LOAD);
  assign cmp_bus1    = bus1_q;
  assign cmp_bus2    = bus2_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench with a transaction-timeline model of the arbiter
module tb_cmp_arbiter;

  localparam int W = 16;
  localparam int N = 2048;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, op0, req1, op1;
  logic [2:0]   cond0, cond1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, taken, busy, cmp_compare, cmp_load;
  logic [W-1:0] result_flags, cmp_bus1, cmp_bus2;
  logic [W-1:0] cflags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .cond0(cond0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .cond1(cond1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .taken(taken), .result_flags(result_flags), .busy(busy),
    .cmp_compare(cmp_compare), .cmp_load(cmp_load),
    .cmp_bus1(cmp_bus1), .cmp_bus2(cmp_bus2), .cmp_flags(cflags)
  );

  // Comparator unit the arbiter drives.
  always @(posedge clk) begin
    if (rst)              cflags <= '0;
    else if (cmp_compare) cflags[1:0] <= {cmp_bus1 > cmp_bus2, cmp_bus1 == cmp_bus2};
    else if (cmp_load)    cflags <= cmp_bus1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit cond_ref(input logic [2:0] c, input logic [1:0] f);
    bit eq, gt, lt;
    eq = f[0];
    gt = f[1];
    lt = !eq && !gt;
    case (c)
      3'd0: return 1'b1;
      3'd1: return eq;
      3'd2: return !eq;
      3'd3: return gt;
      3'd4: return lt;
      3'd5: return gt || eq;
      3'd6: return !gt;
      default: return 1'b0;
    endcase
  endfunction

  // Timeline model: a request accepted at edge k yields grant/issue in cycle k+1,
  // busy for cycles k+1..k+2, done in cycle k+3, next acceptance at edge k+3.
  bit           e_gnt0 [N], e_gnt1 [N], e_done0 [N], e_done1 [N];
  bit           e_cmp [N], e_load [N], e_busy [N], e_tk [N];
  logic [W-1:0] e_rf [N];
  logic [W-1:0] h_rf, h_b1, h_b2, mflags;
  bit           h_tk;
  int           free_at = 0;
  bit           last = 1'b1;

  always @(posedge clk) begin
    int  k;
    bit  w;
    bit  o;
    logic [2:0] c;
    logic [W-1:0] a, b, nf;
    k = cyc;
    if (rst) begin
      armed = 1'b1;
      for (int i = k + 1; i < k + 6 && i < N; i++) begin
        e_gnt0[i] = 0; e_gnt1[i] = 0; e_done0[i] = 0; e_done1[i] = 0;
        e_cmp[i] = 0; e_load[i] = 0; e_busy[i] = 0;
      end
      free_at = k + 1;
      last = 1'b1;
      h_rf = '0; h_tk = 1'b0; h_b1 = '0; h_b2 = '0; mflags = '0;
    end else if (armed && k >= free_at && (req0 || req1) && k + 3 < N) begin
      w = (req0 && req1) ? !last : req1;
      last = w;
      o = w ? op1 : op0;
      c = w ? cond1 : cond0;
      a = w ? a1 : a0;
      b = w ? b1 : b0;
      nf = o ? a : {mflags[W-1:2], a > b, a == b};
      mflags = nf;
      if (w) e_gnt1[k+1] = 1; else e_gnt0[k+1] = 1;
      e_cmp[k+1] = !o;
      e_load[k+1] = o;
      e_busy[k+1] = 1;
      e_busy[k+2] = 1;
      if (w) e_done1[k+3] = 1; else e_done0[k+3] = 1;
      e_rf[k+3] = nf;
      e_tk[k+3] = cond_ref(c, nf[1:0]);
      h_b1 = a;
      h_b2 = b;
      free_at = k + 3;
    end
    cyc = k + 1;
  end

  always @(negedge clk) begin
    if (armed && cyc < N) begin
      if (e_done0[cyc] || e_done1[cyc]) begin
        h_rf = e_rf[cyc];
        h_tk = e_tk[cyc];
      end
      chk("gnt0", gnt0, e_gnt0[cyc]);
      chk("gnt1", gnt1, e_gnt1[cyc]);
      chk("done0", done0, e_done0[cyc]);
      chk("done1", done1, e_done1[cyc]);
      chk("cmp_compare", cmp_compare, e_cmp[cyc]);
      chk("cmp_load", cmp_load, e_load[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("cmp_bus1", cmp_bus1, h_b1);
      chk("cmp_bus2", cmp_bus2, h_b2);
      chk("result_flags", result_flags, h_rf);
      chk("taken", taken, h_tk);
    end
  end

  bit mon_en = 0;
  int order[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
  end

  task automatic do_op(input int who, input bit op, input logic [2:0] cond,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic o_cmp, output logic o_load,
                       output logic [W-1:0] o_b1, output logic [W-1:0] o_b2,
                       output logic [W-1:0] o_rf, output logic o_tk, output int o_lat);
    bit seen;
    int gcyc;
    @(posedge clk); #2;
    if (who == 0) begin req0 = 1; op0 = op; cond0 = cond; a0 = a; b0 = b; end
    else          begin req1 = 1; op1 = op; cond1 = cond; a1 = a; b1 = b; end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (who == 0) ? gnt0 : gnt1;
    end
    chk("gnt_seen", seen, 1);
    gcyc = cyc;
    o_cmp = cmp_compare; o_load = cmp_load; o_b1 = cmp_bus1; o_b2 = cmp_bus2;
    @(posedge clk); #2;
    if (who == 0) req0 = 0; else req1 = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (who == 0) ? done0 : done1;
    end
    chk("done_seen", seen, 1);
    o_rf = result_flags;
    o_tk = taken;
    o_lat = cyc - gcyc;
  endtask

  logic         r_cmp, r_load, r_tk, s_cmp, s_load, s_tk;
  logic [W-1:0] r_b1, r_b2, r_rf, s_b1, s_b2, s_rf;
  int           r_lat, s_lat;
  logic [7:0]   ttab [3];
  logic [W-1:0] pa [3];
  logic [W-1:0] pb [3];
  int           exp_order [4];

  initial begin
    rst = 1; req0 = 0; op0 = 0; cond0 = 0; a0 = 0; b0 = 0;
    req1 = 0; op1 = 0; cond1 = 0; a1 = 0; b1 = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1, done0, done1}, 0);
    chk("rst_flags", result_flags, 0);
    chk("rst_bus1", cmp_bus1, 0);

    // Requester 0 compare 5 vs 5, EQ.
    do_op(0, 0, 3'd1, 16'd5, 16'd5, r_cmp, r_load, r_b1, r_b2, r_rf, r_tk, r_lat);
    chk("t1_compare", {r_cmp, r_load}, 2'b10);
    chk("t1_bus", {r_b1, r_b2}, {16'd5, 16'd5});
    chk("t1_flags", r_rf[1:0], 2'b01);
    chk("t1_taken", r_tk, 1);
    chk("t1_latency", r_lat, 2);

    // Requester 1 alone: GT then LT.
    do_op(1, 0, 3'd3, 16'd1, 16'd0, r_cmp, r_load, r_b1, r_b2, r_rf, r_tk, r_lat);
    chk("t2a_flags", r_rf[1:0], 2'b10);
    chk("t2a_taken", r_tk, 1);
    do_op(1, 0, 3'd4, 16'd0, 16'd1, r_cmp, r_load, r_b1, r_b2, r_rf, r_tk, r_lat);
    chk("t2b_flags", r_rf[1:0], 2'b00);
    chk("t2b_taken", r_tk, 1);

    // Load op.
    do_op(0, 1, 3'd5, 16'h0002, 16'h1234, r_cmp, r_load, r_b1, r_b2, r_rf, r_tk, r_lat);
    chk("t4_strobes", {r_cmp, r_load}, 2'b01);
    chk("t4_flags", r_rf, 16'h0002);
    chk("t4_taken", r_tk, 1);

    // Condition table sweep: flags 00, 01, 10 against all eight codes.
    ttab[0] = 8'h55; ttab[1] = 8'h63; ttab[2] = 8'h2D;
    pa[0] = 16'd3; pb[0] = 16'd9;
    pa[1] = 16'd7; pb[1] = 16'd7;
    pa[2] = 16'd9; pb[2] = 16'd3;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 8; c++) begin
        do_op(0, 0, 3'(c), pa[p], pb[p], r_cmp, r_load, r_b1, r_b2, r_rf, r_tk, r_lat);
        chk($sformatf("cond%0d_flags%0d", c, p), r_tk, ttab[p][c]);
      end
    end

    // Simultaneous requests from reset, each re-asserted after its done.
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    order.delete();
    mon_en = 1;
    fork
      begin
        do_op(0, 0, 3'd1, 16'd4, 16'd4, r_cmp, r_load, r_b1, r_b2, r_rf, r_tk, r_lat);
        do_op(0, 0, 3'd3, 16'd8, 16'd2, r_cmp, r_load, r_b1, r_b2, r_rf, r_tk, r_lat);
      end
      begin
        do_op(1, 0, 3'd2, 16'd4, 16'd6, s_cmp, s_load, s_b1, s_b2, s_rf, s_tk, s_lat);
        do_op(1, 1, 3'd1, 16'h00F1, 16'd0, s_cmp, s_load, s_b1, s_b2, s_rf, s_tk, s_lat);
      end
    join
    mon_en = 0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    chk("tie_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_order%0d", i), (i < order.size()) ? order[i] : -1, exp_order[i]);
    chk("tie_last_taken", s_tk, 1);

    // Reset while in ISSUE aborts the operation.
    @(posedge clk); #2;
    req0 = 1; op0 = 0; cond0 = 3'd1; a0 = 16'd8; b0 = 16'd8;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = gnt0;
      end
      chk("rst_mid_gnt", seen, 1);
    end
    rst = 1; req0 = 0;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_nodone", {done0, done1}, 0);
      @(negedge clk);
    end
    do_op(0, 0, 3'd1, 16'd5, 16'd5, r_cmp, r_load, r_b1, r_b2, r_rf, r_tk, r_lat);
    chk("post_rst_taken", r_tk, 1);
    chk("post_rst_latency", r_lat, 2);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
